riscv_ram_1rw_arbiter: RTL and testbench
========================================

// Module: riscv_ram_1rw_arbiter
// PURPOSE
//  Shares one single-port (1RW) inferred RAM among NPORTS requesters, e.g. I-fetch and D-access.
//  Grants at most one access per cycle, drives the RAM write/read controls and routes read data
//  back to the originating port with a per-port valid strobe.
// PARAMETERS
//  NPORTS  2   number of requesters (2..8)
//  ABITS   10  RAM word-address width
//  DBITS   32  RAM data width; BEBITS=(DBITS+7)/8 byte enables
// PORTS
//  clk_i       in   1              clock; all state updates on rising edge
//  rst_ni      in   1              reset, synchronous, active-low
//  req_i       in   NPORTS         per-port access request
//  gnt_o       out  NPORTS         per-port grant (one-hot or zero), same cycle as req
//  addr_i      in   NPORTS*ABITS   per-port word address, port p at [p*ABITS+:ABITS]
//  we_i        in   NPORTS         per-port write enable (0 = read)
//  be_i        in   NPORTS*BEBITS  per-port byte enables
//  din_i       in   NPORTS*DBITS   per-port write data
//  rvalid_o    out  NPORTS         read data valid for port p
//  rdata_o     out  DBITS          read data, shared by all ports, qualified by rvalid_o
//  ram_addr_o  out  ABITS          to RAM address
//  ram_we_o    out  1              to RAM write enable
//  ram_be_o    out  BEBITS         to RAM byte enables
//  ram_din_o   out  DBITS          to RAM write data
//  ram_dout_i  in   DBITS          from RAM; registered, valid 1 cycle after address
// BEHAVIOUR
//  - Handshake: a port holds req/addr/we/be/din stable until gnt; transfer occurs in the gnt cycle.
//    Dropping req before gnt is allowed; no access then occurs.
//  - Arbitration is round-robin: the search starts at port (last_gnt+1) mod NPORTS; last_gnt is
//    updated only in cycles with a grant. A lone requester is granted every cycle (no bubbles).
//  - RAM mux (combinational): granted port's addr/be/din; ram_we_o = granted & we.
//    No grant: ram_we_o=0, ram_be_o=0, ram_addr_o/ram_din_o = 0.
//  - Read return: a granted read (we=0) sets rd_pend[p]; next cycle rvalid_o[p]=1,
//    rdata_o=ram_dout_i. Latency grant->rvalid = 1. Granted writes never raise rvalid.
//  - Back-to-back reads from different ports: rvalid pulses on successive cycles, in grant order.
//  - Same-port write then read of same address on consecutive grants: read returns new data.
//  - Reset (rst_ni=0 at edge): last_gnt=NPORTS-1 (port 0 wins first), rd_pend=0, rvalid_o=0,
//    rdata_o=0; gnt_o and ram_we_o forced 0 while rst_ni=0. Reads in flight are dropped.
//  - rdata_o holds its last value when no rvalid_o is asserted.
// CONFIGURATION
//  RISCV_RAM_ARB_OREG_EN defined: extra output register on read return; rvalid_o and rdata_o
//    both registered, grant->rvalid latency = 2; pipeline still accepts one grant per cycle.
//  Undefined: latency 1 as above, rdata_o driven directly from ram_dout_i.
// STRUCTURE
//  Package riscv_ram_arb_pkg: MAX_NPORTS=8, function clog2-based PTR width, typedef port_idx_t.
//  Sub-module riscv_rr_arbiter (req vector + last pointer -> one-hot grant, grant index);
//  top holds last_gnt, rd_pend pipeline, RAM mux and read-return logic.
//  Bench wires riscv_ram_1rw_arbiter to the generic 1RW RAM model.
// TESTING
//  1 Port0 write addr 0x005 data 0xDEADBEEF be 4'hF, then port0 read 0x005 -> gnt each cycle,
//    rvalid_o=2'b01 one cycle after read gnt, rdata_o=0xDEADBEEF.
//  2 Both ports req read every cycle (addr 0x010/0x020) -> gnt alternates 01,10,01,10;
//    rvalid alternates with 1-cycle lag, data matches each address.
//  3 Byte enable: write 0x11223344 to 0x003, then be=4'b0010 data 0xAABBCCDD -> read = 0x1122CC44.
//  4 Port1 alone requests 4 reads back-to-back -> gnt_o=10 for 4 cycles, 4 rvalid pulses, no gaps.
//  5 Reset asserted the cycle after a read grant -> no rvalid, gnt 0 during reset; first grant
//    after reset with both requesting goes to port 0.
//  6 With RISCV_RAM_ARB_OREG_EN: repeat test 2 -> identical sequence, rvalid lag 2 cycles.

Source files
------------

// File: rtl/riscv_ram_arb_pkg.sv
// Shared types and constants for the 1RW RAM arbiter.
// Port indices are sized for the largest supported requester count.
package riscv_ram_arb_pkg;

    localparam int MAX_NPORTS = 8;

    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int PTR_W = ptr_width(MAX_NPORTS);

    typedef logic [PTR_W-1:0] port_idx_t;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted port.
// Produces a one-hot grant, the granted index and a grant-valid flag.
module riscv_rr_arbiter
    import riscv_ram_arb_pkg::*;
#(
    parameter int NPORTS = 2
) (
    input  logic [NPORTS-1:0] req_i,
    input  port_idx_t         last_i,
    output logic [NPORTS-1:0] gnt_o,
    output port_idx_t         gnt_idx_o,
    output logic              valid_o
);

    localparam int SW = PTR_W + 1;

    logic [MAX_NPORTS-1:0] req_ext;
    logic [SW-1:0]         sum [NPORTS];
    port_idx_t             cand [NPORTS];

    assign req_ext = MAX_NPORTS'(req_i);

    // cand[k] is the k-th port visited, i.e. (last + 1 + k) mod NPORTS
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, last_i} + SW'(gi + 1);
        assign cand[gi] = (sum[gi] >= SW'(NPORTS)) ? PTR_W'(sum[gi] - SW'(NPORTS))
                                                   : PTR_W'(sum[gi]);
    end

    always_comb begin
        valid_o   = 1'b0;
        gnt_idx_o = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!valid_o && req_ext[cand[i]]) begin
                valid_o   = 1'b1;
                gnt_idx_o = cand[i];
            end
        end
    end

    assign gnt_o = valid_o ? (NPORTS'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/riscv_ram_1rw_arbiter.sv
// Shares one single-port RAM among NPORTS requesters with round-robin grants.
// Define RISCV_RAM_ARB_OREG_EN to register the read return (latency 2 instead of 1).
module riscv_ram_1rw_arbiter
    import riscv_ram_arb_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int ABITS  = 10,
    parameter int DBITS  = 32,
    parameter int BEBITS = (DBITS + 7) / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NPORTS-1:0]        req_i,
    output logic [NPORTS-1:0]        gnt_o,
    input  logic [NPORTS*ABITS-1:0]  addr_i,
    input  logic [NPORTS-1:0]        we_i,
    input  logic [NPORTS*BEBITS-1:0] be_i,
    input  logic [NPORTS*DBITS-1:0]  din_i,
    output logic [NPORTS-1:0]        rvalid_o,
    output logic [DBITS-1:0]         rdata_o,
    output logic [ABITS-1:0]         ram_addr_o,
    output logic                     ram_we_o,
    output logic [BEBITS-1:0]        ram_be_o,
    output logic [DBITS-1:0]         ram_din_o,
    input  logic [DBITS-1:0]         ram_dout_i
);

    port_idx_t          last_gnt_q, last_gnt_d;
    logic [NPORTS-1:0]  rd_pend_q, rd_pend_d;
    logic [DBITS-1:0]   rdata_q, rdata_d;

    logic [NPORTS-1:0]  arb_gnt;
    port_idx_t          arb_idx;
    logic               arb_valid;
    logic               grant_valid;

    logic [ABITS-1:0]   addr_arr [NPORTS];
    logic [BEBITS-1:0]  be_arr   [NPORTS];
    logic [DBITS-1:0]   din_arr  [NPORTS];

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_unpack
        assign addr_arr[gi] = addr_i[gi*ABITS  +: ABITS];
        assign be_arr[gi]   = be_i[gi*BEBITS   +: BEBITS];
        assign din_arr[gi]  = din_i[gi*DBITS   +: DBITS];
    end

    riscv_rr_arbiter #(
        .NPORTS (NPORTS)
    ) u_arb (
        .req_i     (req_i),
        .last_i    (last_gnt_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .valid_o   (arb_valid)
    );

    // No grants are issued while reset is held
    assign grant_valid = arb_valid & rst_ni;
    assign gnt_o       = arb_gnt & {NPORTS{rst_ni}};

    always_comb begin
        ram_addr_o = '0;
        ram_be_o   = '0;
        ram_din_o  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (gnt_o[p]) begin
                ram_addr_o = addr_arr[p];
                ram_be_o   = be_arr[p];
                ram_din_o  = din_arr[p];
            end
        end
    end

    assign ram_we_o   = |(gnt_o & we_i);
    assign rd_pend_d  = gnt_o & ~we_i;
    assign last_gnt_d = grant_valid ? arb_idx : last_gnt_q;

`ifdef RISCV_RAM_ARB_OREG_EN
    logic [NPORTS-1:0] rvalid_q, rvalid_d;

    assign rvalid_d = rd_pend_q;
    assign rdata_d  = (|rd_pend_q) ? ram_dout_i : rdata_q;
    assign rvalid_o = rvalid_q & {NPORTS{rst_ni}};
    assign rdata_o  = rdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end
`else
    // Bypass path: RAM output goes straight out, rdata_q only holds it between pulses
    assign rvalid_o = rd_pend_q & {NPORTS{rst_ni}};
    assign rdata_d  = (|rvalid_o) ? ram_dout_i : rdata_q;
    assign rdata_o  = (|rvalid_o) ? ram_dout_i : rdata_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_gnt_q <= port_idx_t'(NPORTS - 1);
            rd_pend_q  <= '0;
            rdata_q    <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_riscv_ram_1rw_arbiter.sv
// Bench for riscv_ram_1rw_arbiter: directed vector table, then randomized traffic
// against a scoreboard model. Works with or without RISCV_RAM_ARB_OREG_EN.
module tb_riscv_ram_1rw_arbiter;

    localparam int NP = 2;
`ifdef RISCV_RAM_ARB_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, gnt, we, rvalid;
    logic [19:0] addr;
    logic [7:0]  be;
    logic [63:0] din;
    logic [31:0] rdata, ram_din, ram_dout;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_ram_1rw_arbiter #(
        .NPORTS (NP), .ABITS (10), .DBITS (32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .gnt_o      (gnt),
        .addr_i     (addr),
        .we_i       (we),
        .be_i       (be),
        .din_i      (din),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .ram_addr_o (ram_addr),
        .ram_we_o   (ram_we),
        .ram_be_o   (ram_be),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout)
    );

    // Generic 1RW RAM: byte-enabled write, registered read-first output
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) ram[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
        ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic [1:0]  req, we;
        logic [9:0]  a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] d0, d1;
        logic [1:0]  gnt;
        logic [1:0]  rv;     // read return caused by this row, seen LAT rows later
        logic [31:0] rd;
        logic        rd0;    // rdata_o must read zero in this row
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic [1:0] rq, logic [1:0] w, logic [9:0] a0, logic [9:0] a1,
                                logic [3:0] b0, logic [3:0] b1, logic [31:0] d0, logic [31:0] d1,
                                logic [1:0] g, logic [1:0] rv, logic [31:0] rd, logic z);
        vec_t v;
        v.rst_n = r; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.be0 = b0; v.be1 = b1;
        v.d0 = d0; v.d1 = d1; v.gnt = g; v.rv = rv; v.rd = rd; v.rd0 = z;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    endfunction

    // Scoreboard state for the random phase
    typedef struct { int due; int port; logic [31:0] data; } ret_t;
    ret_t        pendq[$];
    logic [31:0] m_mem [1024];
    logic [31:0] m_rdata;
    int          m_last;
    int          cyc;
    logic        act [NP];
    logic        wq [NP];
    logic [9:0]  aq [NP];
    logic [3:0]  beq [NP];
    logic [31:0] dq [NP];

    task automatic drive_ports();
        for (int p = 0; p < NP; p++) begin
            req[p]           = act[p];
            we[p]            = wq[p];
            addr[p*10 +: 10] = aq[p];
            be[p*4 +: 4]     = beq[p];
            din[p*32 +: 32]  = dq[p];
        end
    endtask

    task automatic rstep();
        logic [1:0]  eg, erv;
        logic [31:0] erd;
        int          gp;
        eg = 2'b00; gp = -1;
        if (rst_n) begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (m_last + k) % NP;
                if (gp < 0 && act[p]) gp = p;
            end
        end
        if (gp >= 0) eg[gp] = 1'b1;
        erv = 2'b00; erd = m_rdata;
        if (rst_n) begin
            foreach (pendq[j])
                if (pendq[j].due == cyc) begin
                    erv[pendq[j].port] = 1'b1;
                    erd = pendq[j].data;
                end
        end
        @(negedge clk);
        chk("rnd_gnt", 32'(gnt), 32'(eg));
        chk("rnd_ram_we", 32'(ram_we), (gp >= 0) ? 32'(wq[gp]) : 32'd0);
        chk("rnd_ram_addr", 32'(ram_addr), (gp >= 0) ? 32'(aq[gp]) : 32'd0);
        chk("rnd_ram_be", 32'(ram_be), (gp >= 0) ? 32'(beq[gp]) : 32'd0);
        chk("rnd_rvalid", 32'(rvalid), 32'(erv));
        chk("rnd_rdata", rdata, erd);
        if (!rst_n) begin
            m_last = NP - 1;
            pendq.delete();
            m_rdata = '0;
        end else begin
            m_rdata = erd;
            for (int j = pendq.size() - 1; j >= 0; j--)
                if (pendq[j].due <= cyc) pendq.delete(j);
            if (gp >= 0) begin
                m_last = gp;
                if (wq[gp]) begin
                    for (int b = 0; b < 4; b++)
                        if (beq[gp][b]) m_mem[aq[gp]][b*8 +: 8] = dq[gp][b*8 +: 8];
                end else begin
                    pendq.push_back('{due: cyc + LAT, port: gp, data: m_mem[aq[gp]]});
                end
                act[gp] = 1'b0;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (act[p]) begin
                if ($urandom_range(0, 19) == 0) act[p] = 1'b0;
            end else if ($urandom_range(0, 9) < 6) begin
                act[p] = 1'b1;
                wq[p]  = 1'($urandom_range(0, 1));
                aq[p]  = 10'h100 + 10'($urandom_range(0, 15));
                beq[p] = 4'($urandom_range(0, 15));
                dq[p]  = $urandom;
            end
        end
        @(posedge clk); #1;
        cyc++;
        rst_n = ($urandom_range(0, 63) != 0);
        drive_ports();
    endtask

    logic [1:0]  exp_rv [64];
    logic [31:0] exp_rd [64];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            exp_rv[i] = '0;
            exp_rd[i] = '0;
        end
        rst_n = 1'b0; req = '0; we = '0; addr = '0; be = '0; din = '0;

        tv.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tv.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
        // write then read of the same word
        tv.push_back(mk(1, 2'b01, 2'b01, 10'h005, 0, 4'hF, 0, 32'hDEADBEEF, 0, 2'b01, 2'b00, 0, 0));
        tv.push_back(mk(1, 2'b01, 2'b00, 10'h005, 0, 4'hF, 0, 0, 0, 2'b01, 2'b01, 32'hDEADBEEF, 0));
        tv.push_back(idle()); tv.push_back(idle());
        // byte-enable merge
        tv.push_back(mk(1, 2'b01, 2'b01, 10'h003, 0, 4'hF, 0, 32'h11223344, 0, 2'b01, 2'b00, 0, 0));
        tv.push_back(mk(1, 2'b01, 2'b01, 10'h003, 0, 4'h2, 0, 32'hAABBCCDD, 0, 2'b01, 2'b00, 0, 0));
        tv.push_back(mk(1, 2'b01, 2'b00, 10'h003, 0, 4'hF, 0, 0, 0, 2'b01, 2'b01, 32'h1122CC44, 0));
        tv.push_back(idle()); tv.push_back(idle());
        // preload, then both ports read every cycle
        tv.push_back(mk(1, 2'b11, 2'b11, 10'h010, 10'h020, 4'hF, 4'hF, 32'hA0A00010, 32'hB1B10020, 2'b10, 2'b00, 0, 0));
        tv.push_back(mk(1, 2'b01, 2'b01, 10'h010, 10'h020, 4'hF, 4'hF, 32'hA0A00010, 0, 2'b01, 2'b00, 0, 0));
        tv.push_back(mk(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b10, 2'b10, 32'hB1B10020, 0));
        tv.push_back(mk(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b01, 2'b01, 32'hA0A00010, 0));
        tv.push_back(mk(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b10, 2'b10, 32'hB1B10020, 0));
        tv.push_back(mk(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b01, 2'b01, 32'hA0A00010, 0));
        tv.push_back(idle()); tv.push_back(idle());
        // lone requester streams without bubbles
        tv.push_back(mk(1, 2'b10, 2'b00, 0, 10'h020, 0, 0, 0, 0, 2'b10, 2'b10, 32'hB1B10020, 0));
        tv.push_back(mk(1, 2'b10, 2'b00, 0, 10'h005, 0, 0, 0, 0, 2'b10, 2'b10, 32'hDEADBEEF, 0));
        tv.push_back(mk(1, 2'b10, 2'b00, 0, 10'h003, 0, 0, 0, 0, 2'b10, 2'b10, 32'h1122CC44, 0));
        tv.push_back(mk(1, 2'b10, 2'b00, 0, 10'h010, 0, 0, 0, 0, 2'b10, 2'b10, 32'hA0A00010, 0));
        tv.push_back(idle()); tv.push_back(idle());
        // reset right after a read grant drops the read; port 0 wins afterwards
        tv.push_back(mk(1, 2'b01, 2'b00, 10'h005, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
        tv.push_back(mk(0, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tv.push_back(mk(1, 2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b01, 2'b01, 32'hA0A00010, 1));
        tv.push_back(mk(1, 2'b10, 2'b00, 0, 10'h020, 0, 0, 0, 0, 2'b10, 2'b10, 32'hB1B10020, 0));
        tv.push_back(idle()); tv.push_back(idle());

        @(posedge clk); #1;
        for (int i = 0; i < tv.size(); i++) begin
            rst_n = tv[i].rst_n;
            req   = tv[i].req;
            we    = tv[i].we;
            addr  = {tv[i].a1, tv[i].a0};
            be    = {tv[i].be1, tv[i].be0};
            din   = {tv[i].d1, tv[i].d0};
            @(negedge clk);
            chk("tbl_gnt", 32'(gnt), 32'(tv[i].gnt));
            chk("tbl_ram_we", 32'(ram_we), 32'(|(tv[i].gnt & tv[i].we)));
            chk("tbl_rvalid", 32'(rvalid), 32'(exp_rv[i]));
            if (exp_rv[i] != 2'b00) chk("tbl_rdata", rdata, exp_rd[i]);
            if (tv[i].rd0) chk("tbl_rdata_rst", rdata, 32'd0);
            if (tv[i].rv != 2'b00) begin
                exp_rv[i + LAT] = tv[i].rv;
                exp_rd[i + LAT] = tv[i].rd;
            end
            $display("row %0d rst_n=%0b req=%b gnt=%b rvalid=%b rdata=%h", i, tv[i].rst_n, tv[i].req, gnt, rvalid, rdata);
            @(posedge clk); #1;
        end

        // Random phase: start from a clean reset so the model state is known
        rst_n = 1'b0; req = '0;
        @(posedge clk); #1;
        m_last = NP - 1; m_rdata = '0; cyc = 0; pendq.delete();
        for (int p = 0; p < NP; p++) begin
            act[p] = 1'b0; wq[p] = 1'b0; aq[p] = '0; beq[p] = '0; dq[p] = '0;
        end
        rst_n = 1'b1;
        drive_ports();
        for (int n = 0; n < 1500; n++) rstep();
        $display("random phase: %0d cycles", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
